alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; SHALL be a power of two, >= 2.
REQ-002 CLK  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-low.
REQ-004 CMD_VALID  input  1  upstream command present.
REQ-005 CMD_READY  output  1  FIFO can accept a command.
REQ-006 CMD_A / CMD_B  input  8 each  operands.
REQ-007 CMD_SEL  input  4  operation code, ALU_SEL encoding.
REQ-008 ALU_A / ALU_B  output  8 each  registered operands to downstream ALU.
REQ-009 ALU_SEL  output  4  registered op code to ALU.
REQ-010 ALU_OUT  input  16  ALU result, registered in ALU one cycle after operands are sampled.
REQ-011 CAR_OUT  input  1  ALU carry.
REQ-012 RES_VALID  output  1  result held for consumer.
REQ-013 RES_READY  input  1  consumer accepts result.
REQ-014 RES_DATA  output  16  captured ALU_OUT.
REQ-015 RES_CARRY  output  1  qualified carry.
REQ-016 RES_SEL  output  4  op code of the held result.
REQ-017 RES_ERR  output  1  divide/modulo by zero flag.
REQ-018 FIFO_COUNT  output  log2(DEPTH)+1  commands buffered.

Function
REQ-019 Push SHALL occur on an edge where CMD_VALID=1 and CMD_READY=1; CMD_READY SHALL equal (FIFO_COUNT < DEPTH); no push when full, even if a pop occurs on the same edge.
REQ-020 Simultaneous push and pop when not full SHALL leave FIFO_COUNT unchanged; pointers SHALL wrap modulo DEPTH.
REQ-021 FSM states SHALL be IDLE, ISSUE, CAPTURE, HOLD.
REQ-022 IDLE: if FIFO is non-empty, pop head into ALU_A/ALU_B/ALU_SEL and go to ISSUE; otherwise stay.
REQ-023 ISSUE: ALU_* SHALL stay unchanged; go to CAPTURE unconditionally (the ALU samples on this edge).
REQ-024 CAPTURE: load ALU_OUT into RES_DATA, ALU_SEL into RES_SEL, and set RES_VALID=1; go to HOLD.
REQ-025 HOLD: RES_* SHALL stay stable while RES_VALID=1 and RES_READY=0; on RES_READY=1, clear RES_VALID, then pop the next command and go to ISSUE if the FIFO is non-empty, else go to IDLE.
REQ-026 Latency: a command pushed at edge k into an empty, idle block SHALL produce RES_VALID=1 after edge k+3; back-to-back results with RES_READY held at 1 SHALL come every 3 cycles.
REQ-027 ALU_A/B/SEL SHALL hold their last popped value until the next pop.
REQ-028 RES_CARRY SHALL be CAR_OUT when RES_SEL is 0 or 15, else 0.
REQ-029 RES_ERR SHALL be 1 when RES_SEL is 3 or 4 and the issued B equals 0 (RES_DATA is then 16'hDEAD), else 0.
REQ-030 Results SHALL leave in command order; no command SHALL be dropped or duplicated.

Reset
REQ-031 While RST=0 at an edge: FIFO empty, FIFO_COUNT=0, FSM=IDLE, ALU_A/ALU_B/ALU_SEL=0, RES_VALID/RES_DATA/RES_CARRY/RES_SEL/RES_ERR=0.
REQ-032 Reset mid-operation SHALL discard all queued and in-flight commands and any held result; CMD_READY SHALL be 1 on the first cycle after release.

Structure
REQ-033 Shared package alu_pkg SHALL hold the op-code constants (ADD=0, SUB=1, MUL=2, DIV=3, MOD=4 ... ADDAA=15), the sentinel 16'hDEAD, and the FSM state encoding.
REQ-034 The FIFO SHALL be one sub-module, alu_cmd_fifo (parameter DEPTH, width 20: {SEL,B,A}); the FSM and result register stay in the top module.

Verification
REQ-035 Single op: push A=200, B=100, SEL=0 at edge k, RES_READY=1 -> RES_VALID after edge k+3, RES_DATA=300, RES_CARRY=1, RES_ERR=0.
REQ-036 Divide by zero: A=9, B=0, SEL=3 -> RES_DATA=16'hDEAD, RES_ERR=1, RES_CARRY=0.
REQ-037 Fill: RES_READY=0, push 5 commands, DEPTH=4 -> first pops; FIFO reaches 4; CMD_READY=0; 6th stalls; raise RES_READY -> 5 results in order.
REQ-038 Back-pressure: RES_READY=0 for 10 cycles during HOLD -> RES_DATA/RES_SEL/RES_CARRY unchanged; no pop; ALU_* unchanged.
REQ-039 Reset mid-stream: 3 queued, one in CAPTURE, RST=0 one edge -> all outputs 0, FIFO_COUNT=0, no further results.
REQ-040 Wrap: 12 commands (SEL=5, A=i, B=8'hFF), RES_READY=1 -> RES_DATA=i for i=0..11, in order.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU command sequencer.
//   * 4-bit ALU op-code constants (ALU_SEL encoding)
//   * divide/modulo-by-zero result sentinel
//   * sequencer FSM state encoding
//   * command word layout {SEL,B,A} as stored in the command FIFO
//   * helpers that classify op codes for carry and error qualification
package alu_pkg;

   localparam logic [3:0] ADD   = 4'd0;
   localparam logic [3:0] SUB   = 4'd1;
   localparam logic [3:0] MUL   = 4'd2;
   localparam logic [3:0] DIV   = 4'd3;
   localparam logic [3:0] MOD   = 4'd4;
   localparam logic [3:0] AND   = 4'd5;
   localparam logic [3:0] OR    = 4'd6;
   localparam logic [3:0] XOR   = 4'd7;
   localparam logic [3:0] NAND  = 4'd8;
   localparam logic [3:0] NOR   = 4'd9;
   localparam logic [3:0] XNOR  = 4'd10;
   localparam logic [3:0] SHL   = 4'd11;
   localparam logic [3:0] SHR   = 4'd12;
   localparam logic [3:0] PASSA = 4'd13;
   localparam logic [3:0] PASSB = 4'd14;
   localparam logic [3:0] ADDAA = 4'd15;

   // Result reported in place of the ALU output for a zero divisor.
   localparam logic [15:0] DIV_ZERO_SENTINEL = 16'hDEAD;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } seq_state_t;

   // 20-bit command word, packed as {SEL,B,A}.
   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] b;
      logic [7:0] a;
   } alu_cmd_t;

   // Only the add-type ops produce a carry that means anything downstream.
   function automatic logic carry_qualifies(input logic [3:0] sel);
      return (sel == ADD) || (sel == ADDAA);
   endfunction

   function automatic logic is_div_op(input logic [3:0] sel);
      return (sel == DIV) || (sel == MOD);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo -- synchronous command FIFO, DEPTH entries of alu_cmd_t.
// Ports:
//   CLK, RST       clock, synchronous active-low reset
//   push / wdata   write request; ignored when full (even with a pop)
//   pop  / rdata   read request; rdata shows the head combinationally
//   count          entries held (0..DEPTH)
//   full / empty   status flags
import alu_pkg::*;

module alu_cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push,
   input  logic                     pop,
   input  alu_cmd_t                 wdata,
   output alu_cmd_t                 rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   alu_cmd_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   // Full blocks a push outright; a same-edge pop does not free the slot early.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer -- buffers ALU commands, issues them one at a time to an
// external registered ALU, and holds each result until the consumer takes it.
// Ports:
//   CLK, RST                 clock, synchronous active-low reset
//   CMD_VALID/CMD_READY      command handshake; CMD_A, CMD_B, CMD_SEL payload
//   ALU_A, ALU_B, ALU_SEL    registered operands/op code to the ALU
//   ALU_OUT, CAR_OUT         ALU result and carry (one cycle after sampling)
//   RES_VALID/RES_READY      result handshake
//   RES_DATA, RES_SEL        captured result and its op code
//   RES_CARRY, RES_ERR       qualified carry, divide/modulo-by-zero flag
//   FIFO_COUNT               commands currently buffered
import alu_pkg::*;

module alu_cmd_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     CMD_VALID,
   output logic                     CMD_READY,
   input  logic [7:0]               CMD_A,
   input  logic [7:0]               CMD_B,
   input  logic [3:0]               CMD_SEL,
   output logic [7:0]               ALU_A,
   output logic [7:0]               ALU_B,
   output logic [3:0]               ALU_SEL,
   input  logic [15:0]              ALU_OUT,
   input  logic                     CAR_OUT,
   output logic                     RES_VALID,
   input  logic                     RES_READY,
   output logic [15:0]              RES_DATA,
   output logic                     RES_CARRY,
   output logic [3:0]               RES_SEL,
   output logic                     RES_ERR,
   output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

   seq_state_t state;
   seq_state_t state_nxt;
   alu_cmd_t   wcmd;
   alu_cmd_t   head;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic       div_zero;

   assign wcmd      = '{sel: CMD_SEL, b: CMD_B, a: CMD_A};
   assign CMD_READY = !fifo_full;

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (CMD_VALID),
      .pop   (pop),
      .wdata (wcmd),
      .rdata (head),
      .count (FIFO_COUNT),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge CLK) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // Pops happen only from IDLE or from HOLD on the consuming edge, which
   // makes HOLD->ISSUE->CAPTURE->HOLD a 3-cycle result cadence.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = HOLD;
         HOLD: begin
            if (RES_READY) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand registers change only on a pop so the ALU sees stable inputs
   // through ISSUE and CAPTURE.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         ALU_A   <= '0;
         ALU_B   <= '0;
         ALU_SEL <= '0;
      end else if (pop) begin
         ALU_A   <= head.a;
         ALU_B   <= head.b;
         ALU_SEL <= head.sel;
      end
   end

   // ALU_B still holds the issued divisor during CAPTURE.
   assign div_zero = is_div_op(ALU_SEL) && (ALU_B == 8'd0);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         RES_VALID <= 1'b0;
         RES_DATA  <= '0;
         RES_CARRY <= 1'b0;
         RES_SEL   <= '0;
         RES_ERR   <= 1'b0;
      end else begin
         case (state)
            CAPTURE: begin
               RES_VALID <= 1'b1;
               RES_DATA  <= div_zero ? DIV_ZERO_SENTINEL : ALU_OUT;
               RES_SEL   <= ALU_SEL;
               RES_CARRY <= carry_qualifies(ALU_SEL) && CAR_OUT;
               RES_ERR   <= div_zero;
            end
            HOLD: begin
               if (RES_READY) RES_VALID <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a behavioural registered ALU drives
// ALU_OUT/CAR_OUT, and an in-order queue of expected results (derived from
// each accepted command) is the reference model.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        CMD_VALID = 1'b0;
   logic        CMD_READY;
   logic [7:0]  CMD_A = '0;
   logic [7:0]  CMD_B = '0;
   logic [3:0]  CMD_SEL = '0;
   logic [7:0]  ALU_A;
   logic [7:0]  ALU_B;
   logic [3:0]  ALU_SEL;
   logic [15:0] ALU_OUT = '0;
   logic        CAR_OUT = 1'b0;
   logic        RES_VALID;
   logic        RES_READY = 1'b0;
   logic [15:0] RES_DATA;
   logic        RES_CARRY;
   logic [3:0]  RES_SEL;
   logic        RES_ERR;
   logic [2:0]  FIFO_COUNT;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [15:0] data;
      logic        carry;
      logic        err;
      logic [3:0]  sel;
   } exp_t;

   exp_t exp_q[$];

   alu_cmd_sequencer #(.DEPTH(4)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_SEL(CMD_SEL),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SEL(ALU_SEL),
      .ALU_OUT(ALU_OUT), .CAR_OUT(CAR_OUT),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_DATA(RES_DATA), .RES_CARRY(RES_CARRY), .RES_SEL(RES_SEL),
      .RES_ERR(RES_ERR), .FIFO_COUNT(FIFO_COUNT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // {carry, result}; masked ops deliberately raise carry so qualification shows.
   function automatic logic [16:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] sel);
      logic [16:0] r;
      logic [8:0]  s;
      r = '0;
      case (sel)
         ADD:   begin s = {1'b0, a} + {1'b0, b}; r = {s[8], 7'd0, s}; end
         SUB:   r = {a < b, 8'd0, 8'(a - b)};
         MUL:   r = {1'b1, 16'(a) * 16'(b)};
         DIV:   r = (b == 0) ? {1'b1, 16'hFFFF} : {1'b1, 8'd0, 8'(a / b)};
         MOD:   r = (b == 0) ? {1'b1, 16'hFFFF} : {1'b1, 8'd0, 8'(a % b)};
         AND:   r = {1'b1, 8'd0, a & b};
         OR:    r = {^a, 8'd0, a | b};
         XOR:   r = {1'b0, 8'd0, a ^ b};
         NAND:  r = {1'b1, 8'd0, ~(a & b)};
         NOR:   r = {1'b1, 8'd0, ~(a | b)};
         XNOR:  r = {1'b1, 8'd0, ~(a ^ b)};
         SHL:   r = {a[7], 7'd0, a, 1'b0};
         SHR:   r = {a[0], 8'd0, 1'b0, a[7:1]};
         PASSA: r = {1'b1, 8'd0, a};
         PASSB: r = {1'b1, 8'd0, b};
         ADDAA: begin s = {1'b0, a} + {1'b0, a}; r = {s[8], 7'd0, s}; end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Registered ALU: result appears one cycle after operands are sampled.
   always @(posedge CLK) {CAR_OUT, ALU_OUT} <= alu_model(ALU_A, ALU_B, ALU_SEL);

   function automatic exp_t expect_of(input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] sel);
      exp_t        e;
      logic [16:0] r;
      r     = alu_model(a, b, sel);
      e.sel = sel;
      if ((sel == DIV || sel == MOD) && b == 8'd0) begin
         e.data = 16'hDEAD; e.err = 1'b1; e.carry = 1'b0;
      end else begin
         e.data  = r[15:0];
         e.err   = 1'b0;
         e.carry = (sel == ADD || sel == ADDAA) ? r[16] : 1'b0;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Offer one command; bounded wait for CMD_READY, then push on the next edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
      int w;
      CMD_A = a; CMD_B = b; CMD_SEL = sel; CMD_VALID = 1'b1;
      w = 0;
      while (CMD_READY !== 1'b1 && w < 200) begin tick(); w++; end
      if (CMD_READY !== 1'b1) begin
         checks++; failures++;
         $display("FAIL send_timeout: CMD_READY=%b after %0d cycles, required 1", CMD_READY, w);
      end else begin
         exp_q.push_back(expect_of(a, b, sel));
         tick();
      end
      CMD_VALID = 1'b0;
   endtask

   task automatic do_reset();
      CMD_VALID = 1'b0; RES_READY = 1'b0; RST = 1'b0;
      tick(); tick();
      RST = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      RST = 1'b0; CMD_VALID = 1'b1; CMD_A = 8'h12; CMD_B = 8'h34; RES_READY = 1'b0;
      tick(); tick();
      checks++;
      if ({RES_VALID, RES_DATA, RES_CARRY, RES_SEL, RES_ERR} !== 23'd0) begin
         failures++;
         $display("FAIL reset_res: valid=%b data=%h carry=%b sel=%h err=%b, required all 0",
                  RES_VALID, RES_DATA, RES_CARRY, RES_SEL, RES_ERR);
      end
      checks++;
      if ({ALU_A, ALU_B, ALU_SEL, FIFO_COUNT} !== 23'd0) begin
         failures++;
         $display("FAIL reset_alu: a=%h b=%h sel=%h count=%0d, required all 0",
                  ALU_A, ALU_B, ALU_SEL, FIFO_COUNT);
      end
      CMD_VALID = 1'b0;
      RST = 1'b1;
      checks++;
      if (CMD_READY !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: CMD_READY=%b, required 1", CMD_READY);
      end
      tick();
      checks++;
      if (RES_VALID !== 1'b0 || FIFO_COUNT !== 3'd0) begin
         failures++;
         $display("FAIL reset_idle: valid=%b count=%0d, required 0/0", RES_VALID, FIFO_COUNT);
      end
   endtask

   task automatic test_single();
      do_reset();
      RES_READY = 1'b1;
      CMD_A = 8'd200; CMD_B = 8'd100; CMD_SEL = ADD; CMD_VALID = 1'b1;
      tick();                       // edge k
      CMD_VALID = 1'b0;
      checks++;
      if (FIFO_COUNT !== 3'd1) begin
         failures++;
         $display("FAIL single_count: count=%0d, required 1", FIFO_COUNT);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (RES_VALID !== 1'b0) begin
            failures++;
            $display("FAIL single_early: RES_VALID=%b after edge k+%0d, required 0", RES_VALID, i);
         end
         tick();
      end
      checks++;
      if ({RES_VALID, RES_DATA, RES_CARRY, RES_ERR, RES_SEL} !== {1'b1, 16'd300, 1'b1, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL single_result: valid=%b data=%0d carry=%b err=%b sel=%0d, required 1/300/1/0/0",
                  RES_VALID, RES_DATA, RES_CARRY, RES_ERR, RES_SEL);
      end
      tick();
      checks++;
      if (RES_VALID !== 1'b0) begin
         failures++;
         $display("FAIL single_clear: RES_VALID=%b after consume, required 0", RES_VALID);
      end
   endtask

   task automatic test_div_zero();
      logic [3:0] ops [2];
      ops[0] = DIV; ops[1] = MOD;
      for (int k = 0; k < 2; k++) begin
         int w;
         do_reset();
         RES_READY = 1'b1;
         CMD_A = 8'd9; CMD_B = 8'd0; CMD_SEL = ops[k]; CMD_VALID = 1'b1;
         tick();
         CMD_VALID = 1'b0;
         w = 0;
         while (RES_VALID !== 1'b1 && w < 10) begin tick(); w++; end
         checks++;
         if ({RES_VALID, RES_DATA, RES_ERR, RES_CARRY, RES_SEL} !== {1'b1, 16'hDEAD, 1'b1, 1'b0, ops[k]}) begin
            failures++;
            $display("FAIL div_zero_%0d: valid=%b data=%h err=%b carry=%b sel=%0d, required 1/dead/1/0/%0d",
                     k, RES_VALID, RES_DATA, RES_ERR, RES_CARRY, RES_SEL, ops[k]);
         end
         tick();
      end
   endtask

   task automatic test_fill();
      int   got;
      exp_t e;
      do_reset();
      RES_READY = 1'b0;
      for (int i = 0; i < 5; i++) send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      checks++;
      if ({FIFO_COUNT, CMD_READY, RES_VALID} !== {3'd4, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL fill_full: count=%0d ready=%b valid=%b, required 4/0/1",
                  FIFO_COUNT, CMD_READY, RES_VALID);
      end
      // Sixth command must stall while the FIFO is full.
      CMD_A = 8'hAA; CMD_B = 8'h55; CMD_SEL = XOR; CMD_VALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (FIFO_COUNT !== 3'd4 || CMD_READY !== 1'b0) begin
            failures++;
            $display("FAIL fill_stall: count=%0d ready=%b, required 4/0", FIFO_COUNT, CMD_READY);
         end
      end
      CMD_VALID = 1'b0;
      RES_READY = 1'b1;
      got = 0;
      for (int c = 0; c < 60 && got < 5; c++) begin
         if (RES_VALID === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL fill_extra: unexpected result data=%h", RES_DATA);
            end else begin
               e = exp_q.pop_front();
               if ({RES_DATA, RES_CARRY, RES_ERR, RES_SEL} !== {e.data, e.carry, e.err, e.sel}) begin
                  failures++;
                  $display("FAIL fill_result%0d: data=%h carry=%b err=%b sel=%h, required %h/%b/%b/%h",
                           got, RES_DATA, RES_CARRY, RES_ERR, RES_SEL, e.data, e.carry, e.err, e.sel);
               end
            end
            got++;
         end
         tick();
      end
      repeat (10) begin
         if (RES_VALID === 1'b1) got++;
         tick();
      end
      checks++;
      if (got !== 5) begin
         failures++;
         $display("FAIL fill_count: results=%0d, required 5", got);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] a0, b0;
      int         w, got;
      exp_t       e;
      do_reset();
      RES_READY = 1'b0;
      a0 = 8'($urandom_range(128, 255));
      b0 = 8'($urandom_range(128, 255));
      send(a0, b0, ADD);
      send(8'($urandom), 8'($urandom), SUB);
      send(8'($urandom), 8'($urandom), MUL);
      e = expect_of(a0, b0, ADD);
      w = 0;
      while (RES_VALID !== 1'b1 && w < 10) begin tick(); w++; end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({RES_VALID, RES_DATA, RES_SEL, RES_CARRY, RES_ERR, ALU_A, ALU_B, ALU_SEL, FIFO_COUNT} !==
             {1'b1, e.data, e.sel, e.carry, e.err, a0, b0, ADD, 3'd2}) begin
            failures++;
            $display("FAIL bp_hold%0d: valid=%b data=%h sel=%h carry=%b alu=%h/%h/%h count=%0d, required 1/%h/%h/%b %h/%h/0 2",
                     i, RES_VALID, RES_DATA, RES_SEL, RES_CARRY, ALU_A, ALU_B, ALU_SEL, FIFO_COUNT,
                     e.data, e.sel, e.carry, a0, b0);
         end
         tick();
      end
      RES_READY = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 3; c++) begin
         if (RES_VALID === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL bp_extra: unexpected result data=%h", RES_DATA);
            end else begin
               e = exp_q.pop_front();
               if ({RES_DATA, RES_CARRY, RES_ERR, RES_SEL} !== {e.data, e.carry, e.err, e.sel}) begin
                  failures++;
                  $display("FAIL bp_result%0d: data=%h carry=%b err=%b sel=%h, required %h/%b/%b/%h",
                           got, RES_DATA, RES_CARRY, RES_ERR, RES_SEL, e.data, e.carry, e.err, e.sel);
               end
            end
            got++;
         end
         tick();
      end
      checks++;
      if (got !== 3) begin
         failures++;
         $display("FAIL bp_count: results=%0d, required 3", got);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   seen;
      do_reset();
      RES_READY = 1'b0;
      for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      e = exp_q[0];
      checks++;
      if ({RES_VALID, RES_DATA, RES_SEL, FIFO_COUNT} !== {1'b1, e.data, e.sel, 3'd3}) begin
         failures++;
         $display("FAIL rmid_setup: valid=%b data=%h sel=%h count=%0d, required 1/%h/%h/3",
                  RES_VALID, RES_DATA, RES_SEL, FIFO_COUNT, e.data, e.sel);
      end
      RES_READY = 1'b1;
      send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));  // consume + pop + push
      RES_READY = 1'b0;
      tick();                                                        // now in CAPTURE
      checks++;
      if (FIFO_COUNT !== 3'd3) begin
         failures++;
         $display("FAIL rmid_queued: count=%0d, required 3", FIFO_COUNT);
      end
      RST = 1'b0;
      tick();
      checks++;
      if ({RES_VALID, RES_DATA, RES_CARRY, RES_SEL, RES_ERR, ALU_A, ALU_B, ALU_SEL, FIFO_COUNT} !== 46'd0) begin
         failures++;
         $display("FAIL rmid_clear: valid=%b data=%h carry=%b sel=%h err=%b alu=%h/%h/%h count=%0d, required all 0",
                  RES_VALID, RES_DATA, RES_CARRY, RES_SEL, RES_ERR, ALU_A, ALU_B, ALU_SEL, FIFO_COUNT);
      end
      RST = 1'b1;
      exp_q.delete();
      RES_READY = 1'b1;
      checks++;
      if (CMD_READY !== 1'b1) begin
         failures++;
         $display("FAIL rmid_ready: CMD_READY=%b after release, required 1", CMD_READY);
      end
      seen = 0;
      repeat (20) begin
         tick();
         if (RES_VALID !== 1'b0 || FIFO_COUNT !== 3'd0) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL rmid_quiet: %0d cycles with activity after reset, required 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      RES_READY = 1'b1;
      fork
         begin
            for (int i = 0; i < 12; i++) send(8'(i), 8'hFF, AND);
         end
         begin
            int   got, last;
            exp_t e;
            got = 0; last = 0;
            for (int c = 0; c < 200 && got < 12; c++) begin
               if (RES_VALID === 1'b1) begin
                  checks++;
                  e = expect_of(8'(got), 8'hFF, AND);
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
                  if ({RES_DATA, RES_SEL, RES_CARRY, RES_ERR} !== {16'(got), AND, 1'b0, 1'b0} ||
                      RES_DATA !== e.data) begin
                     failures++;
                     $display("FAIL wrap_result%0d: data=%0d sel=%0d carry=%b err=%b, required %0d/5/0/0",
                              got, RES_DATA, RES_SEL, RES_CARRY, RES_ERR, got);
                  end
                  if (got > 0) begin
                     checks++;
                     if (cyc - last !== 3) begin
                        failures++;
                        $display("FAIL wrap_cadence%0d: spacing=%0d cycles, required 3", got, cyc - last);
                     end
                  end
                  last = cyc;
                  got++;
               end
               tick();
            end
            checks++;
            if (got !== 12) begin
               failures++;
               $display("FAIL wrap_count: results=%0d, required 12", got);
            end
         end
      join
   endtask

   task automatic test_random();
      localparam int N = 40;
      do_reset();
      fork
         begin
            for (int i = 0; i < N; i++) begin
               logic [7:0] b;
               repeat ($urandom_range(0, 2)) tick();
               b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
               send(8'($urandom), b, 4'($urandom_range(0, 15)));
            end
         end
         begin
            int   got;
            exp_t e;
            got = 0;
            for (int c = 0; c < 3000 && got < N; c++) begin
               RES_READY = ($urandom_range(0, 3) != 0);
               if (RES_VALID === 1'b1 && RES_READY) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL rand_extra: unexpected result data=%h", RES_DATA);
                  end else begin
                     e = exp_q.pop_front();
                     if ({RES_DATA, RES_CARRY, RES_ERR, RES_SEL} !== {e.data, e.carry, e.err, e.sel}) begin
                        failures++;
                        $display("FAIL rand_result%0d: data=%h carry=%b err=%b sel=%h, required %h/%b/%b/%h",
                                 got, RES_DATA, RES_CARRY, RES_ERR, RES_SEL, e.data, e.carry, e.err, e.sel);
                     end
                  end
                  got++;
               end
               tick();
            end
            checks++;
            if (got !== N) begin
               failures++;
               $display("FAIL rand_count: results=%0d, required %0d", got, N);
            end
         end
      join
      RES_READY = 1'b1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_div_zero();
      test_fill();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
